// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin grant arbiter.
// Provides the FSM state encoding and a width helper that never returns zero.
package rr_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Index width for n items, at least 1 bit so a single requester still has a port.
  function automatic int unsigned clogb2(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'd1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
// Handshake: req is a level held by a requester for as long as it wants the resource; gnt is a registered one-hot that stays on the owner until its req drops (or it is preempted), and may move directly to the next owner with no idle cycle.
interface rr_grant_arbiter_if #(
  parameter int WIDTH   = 8,
  parameter int WIDTH_W = rr_arb_pkg::clogb2(WIDTH)
);
  import rr_arb_pkg::*;

  logic [WIDTH-1:0]   req;
  logic [WIDTH-1:0]   gnt;
  logic               gnt_valid;
  logic [WIDTH_W-1:0] gnt_bin;
  logic               timeout_err;
  logic [WIDTH_W-1:0] timeout_bin;
  state_t             state;

  modport master (
    output req,
    input  gnt, gnt_valid, gnt_bin, timeout_err, timeout_bin, state
  );

  modport slave (
    input  req,
    output gnt, gnt_valid, gnt_bin, timeout_err, timeout_bin, state
  );

endinterface

// File: rtl/rr_next_pick.sv
// Combinational round-robin search: first set bit of req strictly after last, wrapping.
// Searches a double-width buffer whose low half is masked to indices above last.
module rr_next_pick
  import rr_arb_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int WIDTH_W = clogb2(WIDTH)
) (
  input  logic [WIDTH-1:0]   req,
  input  logic [WIDTH_W-1:0] last,
  output logic               pick_valid,
  output logic [WIDTH_W-1:0] pick_bin,
  output logic [WIDTH-1:0]   pick_onehot
);

  logic [WIDTH-1:0]   above;
  logic [2*WIDTH-1:0] search;

  always_comb begin
    above = '0;
    for (int i = 0; i < WIDTH; i++) begin
      above[i] = (i > int'(last));
    end
    search     = {req, req & above};
    pick_valid = |req;
    pick_bin   = '0;
    // Walk downward so the lowest set position of the buffer wins.
    for (int i = 2*WIDTH-1; i >= 0; i--) begin
      if (search[i]) pick_bin = (i >= WIDTH) ? WIDTH_W'(i - WIDTH) : WIDTH_W'(i);
    end
    pick_onehot           = '0;
    pick_onehot[pick_bin] = pick_valid;
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with registered one-hot grant held until the owner releases.
// Define RR_ARB_TIMEOUT_EN to add owner preemption after MAX_HOLD grant cycles.
module rr_grant_arbiter
  import rr_arb_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int WIDTH_W  = clogb2(WIDTH),
  parameter int MAX_HOLD = 16
) (
  input logic               clk,
  input logic               nrst,
  rr_grant_arbiter_if.slave arb
);

  if (WIDTH < 1 || MAX_HOLD < 2) begin : g_param_check
    $error("rr_grant_arbiter: WIDTH must be >= 1 and MAX_HOLD >= 2");
  end

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   gnt_q, gnt_d;
  logic               valid_q;
  logic [WIDTH_W-1:0] owner_q, owner_d;
  logic [WIDTH_W-1:0] last_q, last_d;
  logic               terr_q, terr_d;
  logic [WIDTH_W-1:0] tbin_q, tbin_d;

  logic [WIDTH-1:0]   eligible;
  logic [WIDTH-1:0]   pick_req;
  logic [WIDTH_W-1:0] pick_last;
  logic               pick_valid;
  logic [WIDTH_W-1:0] pick_bin;
  logic [WIDTH-1:0]   pick_onehot;

`ifdef RR_ARB_TIMEOUT_EN
  localparam int HOLD_W = clogb2(MAX_HOLD + 1);
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [WIDTH-1:0]  blocked_q, blocked_d;

  assign eligible = arb.req & ~blocked_q;
`else
  assign eligible = arb.req;
`endif

  // While granted, search from the owner and exclude it, so a hit means a true competitor.
  assign pick_req  = eligible & ~((state_q == GRANT) ? gnt_q : '0);
  assign pick_last = (state_q == GRANT) ? owner_q : last_q;

  rr_next_pick #(
    .WIDTH   (WIDTH),
    .WIDTH_W (WIDTH_W)
  ) u_next_pick (
    .req         (pick_req),
    .last        (pick_last),
    .pick_valid  (pick_valid),
    .pick_bin    (pick_bin),
    .pick_onehot (pick_onehot)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    terr_d  = 1'b0;
    tbin_d  = tbin_q;
`ifdef RR_ARB_TIMEOUT_EN
    hold_d    = hold_q;
    blocked_d = blocked_q & arb.req;
`endif
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = GRANT;
          gnt_d   = pick_onehot;
          owner_d = pick_bin;
`ifdef RR_ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      GRANT: begin
        if (!arb.req[owner_q]) begin
          last_d = owner_q;
          if (pick_valid) begin
            gnt_d   = pick_onehot;
            owner_d = pick_bin;
`ifdef RR_ARB_TIMEOUT_EN
            hold_d  = '0;
`endif
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            owner_d = '0;
          end
        end
`ifdef RR_ARB_TIMEOUT_EN
        // Count reaches MAX_HOLD on this edge (or already saturated there): preempt.
        else if (pick_valid && hold_q >= HOLD_W'(MAX_HOLD - 1)) begin
          last_d             = owner_q;
          gnt_d              = pick_onehot;
          owner_d            = pick_bin;
          hold_d             = '0;
          terr_d             = 1'b1;
          tbin_d             = owner_q;
          blocked_d[owner_q] = 1'b1;
        end else if (hold_q != HOLD_W'(MAX_HOLD)) begin
          hold_d = hold_q + HOLD_W'(1);
        end
`endif
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        owner_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      owner_q <= '0;
      last_q  <= WIDTH_W'(WIDTH - 1);
      terr_q  <= 1'b0;
      tbin_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      valid_q <= |gnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      terr_q  <= terr_d;
      tbin_q  <= tbin_d;
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!nrst) begin
      hold_q    <= '0;
      blocked_q <= '0;
    end else begin
      hold_q    <= hold_d;
      blocked_q <= blocked_d;
    end
  end
`endif

  assign arb.gnt         = gnt_q;
  assign arb.gnt_valid   = valid_q;
  assign arb.gnt_bin     = owner_q;
  assign arb.timeout_err = terr_q;
  assign arb.timeout_bin = tbin_q;
  assign arb.state       = state_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter at WIDTH=4, MAX_HOLD=4; vector table plus corner sequences.
// Expectations for the preemption sequence follow RR_ARB_TIMEOUT_EN when it is defined.
module tb_rr_grant_arbiter;
  import rr_arb_pkg::*;

  localparam int WIDTH    = 4;
  localparam int WIDTH_W  = 2;
  localparam int MAX_HOLD = 4;

  typedef struct {
    logic               nrst;
    logic [WIDTH-1:0]   req;
    logic [WIDTH-1:0]   gnt;
    logic [WIDTH_W-1:0] gnt_bin;
  } vec_t;

  logic clk;
  logic nrst;
  int   vectors;
  int   miscompares;

  rr_grant_arbiter_if #(.WIDTH(WIDTH), .WIDTH_W(WIDTH_W)) bus ();

  rr_grant_arbiter #(
    .WIDTH    (WIDTH),
    .WIDTH_W  (WIDTH_W),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .arb  (bus.slave)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs, then sample just after the active edge.
  task automatic apply(input logic n, input logic [WIDTH-1:0] r);
    nrst    = n;
    bus.req = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [WIDTH-1:0] eg, input logic [WIDTH_W-1:0] eb,
                       input logic et, input logic [WIDTH_W-1:0] etb);
    vectors++;
    if (bus.gnt !== eg) begin
      miscompares++;
      $display("FAIL %s gnt: got %b expected %b", tag, bus.gnt, eg);
    end
    if (bus.gnt_valid !== (eg != '0)) begin
      miscompares++;
      $display("FAIL %s gnt_valid: got %b expected %b", tag, bus.gnt_valid, (eg != '0));
    end
    if (bus.gnt_bin !== eb) begin
      miscompares++;
      $display("FAIL %s gnt_bin: got %0d expected %0d", tag, bus.gnt_bin, eb);
    end
    if (bus.timeout_err !== et) begin
      miscompares++;
      $display("FAIL %s timeout_err: got %b expected %b", tag, bus.timeout_err, et);
    end
    if (bus.timeout_bin !== etb) begin
      miscompares++;
      $display("FAIL %s timeout_bin: got %0d expected %0d", tag, bus.timeout_bin, etb);
    end
  endtask

  vec_t tbl[24];

  initial begin
    vectors     = 0;
    miscompares = 0;
    nrst        = 1'b0;
    bus.req     = '0;

    // reset, single request, release-with-handover, wrap
    tbl[0]  = '{1'b0, 4'b0000, 4'b0000, 2'd0};
    tbl[1]  = '{1'b0, 4'b0000, 4'b0000, 2'd0};
    tbl[2]  = '{1'b1, 4'b1010, 4'b0010, 2'd1};
    tbl[3]  = '{1'b1, 4'b1011, 4'b0010, 2'd1};
    tbl[4]  = '{1'b1, 4'b1001, 4'b1000, 2'd3};
    tbl[5]  = '{1'b1, 4'b1001, 4'b1000, 2'd3};
    tbl[6]  = '{1'b1, 4'b0001, 4'b0001, 2'd0};
    tbl[7]  = '{1'b1, 4'b0000, 4'b0000, 2'd0};
    // all requesting: order 0,1,2,3,0 with no idle cycle
    tbl[8]  = '{1'b0, 4'b0000, 4'b0000, 2'd0};
    tbl[9]  = '{1'b1, 4'b1111, 4'b0001, 2'd0};
    tbl[10] = '{1'b1, 4'b1111, 4'b0001, 2'd0};
    tbl[11] = '{1'b1, 4'b1110, 4'b0010, 2'd1};
    tbl[12] = '{1'b1, 4'b1111, 4'b0010, 2'd1};
    tbl[13] = '{1'b1, 4'b1101, 4'b0100, 2'd2};
    tbl[14] = '{1'b1, 4'b1111, 4'b0100, 2'd2};
    tbl[15] = '{1'b1, 4'b1011, 4'b1000, 2'd3};
    tbl[16] = '{1'b1, 4'b1111, 4'b1000, 2'd3};
    tbl[17] = '{1'b1, 4'b0111, 4'b0001, 2'd0};
    tbl[18] = '{1'b1, 4'b0000, 4'b0000, 2'd0};
    // sole owner releases and re-requests: one idle cycle
    tbl[19] = '{1'b1, 4'b0100, 4'b0100, 2'd2};
    tbl[20] = '{1'b1, 4'b0100, 4'b0100, 2'd2};
    tbl[21] = '{1'b1, 4'b0000, 4'b0000, 2'd0};
    tbl[22] = '{1'b1, 4'b0100, 4'b0100, 2'd2};
    tbl[23] = '{1'b1, 4'b0000, 4'b0000, 2'd0};

    for (int i = 0; i < 24; i++) begin
      apply(tbl[i].nrst, tbl[i].req);
      check($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].gnt_bin, 1'b0, 2'd0);
    end

    // Long hold with a competitor arriving one cycle after the grant
    apply(1'b0, 4'b0000);
    check("to_reset", 4'b0000, 2'd0, 1'b0, 2'd0);
    apply(1'b1, 4'b0001);
    check("to_grant0", 4'b0001, 2'd0, 1'b0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 4'b0101);
      check($sformatf("to_hold%0d", i), 4'b0001, 2'd0, 1'b0, 2'd0);
    end
    apply(1'b1, 4'b0101);
`ifdef RR_ARB_TIMEOUT_EN
    check("to_preempt", 4'b0100, 2'd2, 1'b1, 2'd0);
    apply(1'b1, 4'b0101);
    check("to_after", 4'b0100, 2'd2, 1'b0, 2'd0);
    apply(1'b1, 4'b0001);
    check("to_blocked", 4'b0000, 2'd0, 1'b0, 2'd0);
`else
    check("to_preempt", 4'b0001, 2'd0, 1'b0, 2'd0);
    apply(1'b1, 4'b0101);
    check("to_after", 4'b0001, 2'd0, 1'b0, 2'd0);
    apply(1'b1, 4'b0001);
    check("to_blocked", 4'b0001, 2'd0, 1'b0, 2'd0);
`endif
    apply(1'b1, 4'b0000);
    check("to_release", 4'b0000, 2'd0, 1'b0, 2'd0);
    apply(1'b1, 4'b0001);
    check("to_regrant", 4'b0001, 2'd0, 1'b0, 2'd0);

    // Reset while granted, then restart from index 0
    apply(1'b0, 4'b0000);
    apply(1'b1, 4'b0100);
    check("rst_grant2", 4'b0100, 2'd2, 1'b0, 2'd0);
    apply(1'b0, 4'b0100);
    check("rst_drop", 4'b0000, 2'd0, 1'b0, 2'd0);
    apply(1'b1, 4'b1111);
    check("rst_restart", 4'b0001, 2'd0, 1'b0, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
